countdown_timer_mmss: RTL



---
 rtl/countdown_timer_mmss.sv | 109 ++++++++++
 1 files changed

// File: rtl/countdown_timer_mmss.sv
// MM:SS down-counter built from four BCD digits joined by a borrow chain.
// Has load/start/pause control, and flags expiry when the count reaches 00:00.
module countdown_timer_mmss #(
    parameter int MAX_MIN_T = 5,
    parameter int MAX_SEC_T = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] set_min_t,
    input  logic [3:0] set_min_u,
    input  logic [3:0] set_sec_t,
    input  logic [3:0] set_sec_u,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);
    localparam logic [3:0] MMT = 4'(MAX_MIN_T);
    localparam logic [3:0] MST = 4'(MAX_SEC_T);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] min_t_nx, min_u_nx, sec_t_nx, sec_u_nx;
    logic [3:0] dec_min_t, dec_min_u, dec_sec_t, dec_sec_u;
    logic       borrow0, borrow1, borrow2;
    logic       expired_nx, load_err_nx;
    logic       legal, nonzero, last_sec;

    assign legal    = (set_sec_u <= 4'd9) && (set_min_u <= 4'd9) &&
                      (set_sec_t <= MST) && (set_min_t <= MMT);
    assign nonzero  = |{min_t, min_u, sec_t, sec_u};
    assign last_sec = ({min_t, min_u, sec_t} == 12'd0) && (sec_u == 4'd1);

    // Borrow chain: each digit wraps to its maximum and borrows from the next.
    assign borrow0   = (sec_u == 4'd0);
    assign dec_sec_u = borrow0 ? 4'd9 : sec_u - 4'd1;
    assign borrow1   = borrow0 && (sec_t == 4'd0);
    assign dec_sec_t = borrow0 ? ((sec_t == 4'd0) ? MST : sec_t - 4'd1) : sec_t;
    assign borrow2   = borrow1 && (min_u == 4'd0);
    assign dec_min_u = borrow1 ? ((min_u == 4'd0) ? 4'd9 : min_u - 4'd1) : min_u;
    assign dec_min_t = borrow2 ? min_t - 4'd1 : min_t;

    always_comb begin
        state_nx    = state;
        min_t_nx    = min_t;
        min_u_nx    = min_u;
        sec_t_nx    = sec_t;
        sec_u_nx    = sec_u;
        expired_nx  = 1'b0;
        load_err_nx = 1'b0;
        if (load && state != RUN) begin
            if (legal) begin
                min_t_nx = set_min_t;
                min_u_nx = set_min_u;
                sec_t_nx = set_sec_t;
                sec_u_nx = set_sec_u;
                state_nx = IDLE;
            end else begin
                load_err_nx = 1'b1;
            end
        end else if (pause) begin
            if (state == RUN) state_nx = PAUSE;
        end else if (start) begin
            if ((state == IDLE || state == PAUSE) && nonzero) state_nx = RUN;
        end else if (tick && !load && state == RUN) begin
            // A load strobe during RUN is ignored, but it still swallows the tick.
            min_t_nx = dec_min_t;
            min_u_nx = dec_min_u;
            sec_t_nx = dec_sec_t;
            sec_u_nx = dec_sec_u;
            if (last_sec) begin
                state_nx   = DONE;
                expired_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            min_t    <= 4'd0;
            min_u    <= 4'd0;
            sec_t    <= 4'd0;
            sec_u    <= 4'd0;
            expired  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            min_t    <= min_t_nx;
            min_u    <= min_u_nx;
            sec_t    <= sec_t_nx;
            sec_u    <= sec_u_nx;
            expired  <= expired_nx;
            load_err <= load_err_nx;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);
endmodule
